// File: rtl/cache_pkg.sv
// Shared cache definitions: fill-state encoding and block geometry, used by the
// fill engine, the memory arbiter and the caches.
package cache_pkg;

   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned OFFSET_W        = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned MEM_LATENCY     = 4;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDrain
   } fill_state_e;

endpackage

// File: rtl/fill_word_counter.sv
// Clearable, enabled, wrapping word counter; done flags the event that carries
// the count past LAST.
module fill_word_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LAST  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             done
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = en && (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill engine: streams one cache block from pipelined memory into the data
// array, then writes the tag. Define CACHE_FILL_CRIT_WORD_EN for critical-word-first.
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               miss_detected,
   input  logic [ADDR_W-1:0]                  miss_address,
   input  logic                               mem_grant,
   input  logic                               memory_data_valid,
   input  logic [DATA_W-1:0]                  memory_data,
   output logic                               fsm_busy,
   output logic                               mem_read_en,
   output logic [ADDR_W-1:0]                  memory_address,
   output logic                               write_data_array,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
   output logic [DATA_W-1:0]                  fill_data,
   output logic                               write_tag_array,
   output logic                               fill_done
);

   localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned BASE_W = ADDR_W - OFF_W - 1;

   fill_state_e       state;
   logic [BASE_W-1:0] base_q;
   logic [OFF_W-1:0]  start_q;
   logic [OFF_W-1:0]  start_off;
   logic [OFF_W-1:0]  issue_off;
   logic [OFF_W-1:0]  recv_off;
   logic [OFF_W:0]    issue_cnt;
   logic [OFF_W:0]    recv_cnt;
   logic              issue_done;
   logic              recv_done;
   logic              start_fill;
   logic              issue_fire;
   logic              recv_fire;
   logic              unused_addr;

`ifdef CACHE_FILL_CRIT_WORD_EN
   assign start_off   = miss_address[OFF_W:1];
   assign unused_addr = miss_address[0];
`else
   assign start_off   = '0;
   assign unused_addr = ^miss_address[OFF_W:0];
`endif

   assign start_fill = (state == StIdle) && miss_detected;
   assign issue_fire = (state == StReq) && mem_grant;
   // A return with nothing outstanding is stale (e.g. from before a reset).
   assign recv_fire  = (state != StIdle) && memory_data_valid && (recv_cnt != issue_cnt);

   assign issue_off = start_q + issue_cnt[OFF_W-1:0];
   assign recv_off  = start_q + recv_cnt[OFF_W-1:0];

   fill_word_counter #(
      .WIDTH (OFF_W + 1),
      .LAST  (WORDS_PER_BLOCK - 1)
   ) u_issue_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_fill),
      .en   (issue_fire),
      .cnt  (issue_cnt),
      .done (issue_done)
   );

   fill_word_counter #(
      .WIDTH (OFF_W + 1),
      .LAST  (WORDS_PER_BLOCK - 1)
   ) u_recv_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_fill),
      .en   (recv_fire),
      .cnt  (recv_cnt),
      .done (recv_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= StIdle;
         base_q  <= '0;
         start_q <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (miss_detected) begin
                  base_q  <= miss_address[ADDR_W-1:OFF_W+1];
                  start_q <= start_off;
                  state   <= StReq;
               end
            end
            StReq: begin
               if (issue_done) begin
                  state <= StDrain;
               end
            end
            StDrain: begin
               if (recv_done) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Outputs follow grant/valid in the same cycle; all are held low during reset.
   assign fsm_busy         = rst && ((state != StIdle) || miss_detected);
   assign mem_read_en      = rst && issue_fire;
   assign memory_address   = mem_read_en ? {base_q, issue_off, 1'b0} : '0;
   assign write_data_array = rst && recv_fire;
   assign data_word_offset = write_data_array ? recv_off : '0;
   assign fill_data        = write_data_array ? memory_data : '0;
   assign write_tag_array  = write_data_array && recv_done;
   assign fill_done        = write_tag_array;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: pipelined memory model, per-cycle reference model of
// the fill rules, and directed scenarios with literal timing/address expectations.
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        mem_grant;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy;
   logic        mem_read_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word_offset;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic        fill_done;

   logic        mem_v;
   logic [15:0] mem_d;
   logic        inj_v;
   logic [15:0] inj_d;

   typedef struct {
      int          due;
      logic [15:0] d;
   } ret_t;

   ret_t        mem_q[$];
   int          rd_cyc_q[$];
   logic [15:0] rd_addr_q[$];
   logic [2:0]  off_q[$];
   int          done_q[$];

   int cyc;
   int n_tests;
   int n_fail;

   assign memory_data_valid = mem_v | inj_v;
   assign memory_data       = inj_v ? inj_d : mem_d;

   cache_fill_fsm u_dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .mem_grant         (mem_grant),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_read_en       (mem_read_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word_offset  (data_word_offset),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory: answers each read 4 cycles later with a word derived from its address.
   initial begin
      mem_v = 1'b0;
      mem_d = '0;
      cyc   = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            mem_v = 1'b1;
            mem_d = mem_q[0].d;
            void'(mem_q.pop_front());
         end else begin
            mem_v = 1'b0;
            mem_d = '0;
         end
      end
   end

   // Reference model: a fill is a count of issued and returned words over one block.
   initial begin
      bit          m_active;
      logic [11:0] m_base;
      logic [2:0]  m_start;
      int          m_reads;
      int          m_writes;
      logic        e_busy, e_rd, e_wr, e_done;
      logic [2:0]  e_off;
      logic [15:0] e_addr;
      m_active = 0;
      m_base   = '0;
      m_start  = '0;
      m_reads  = 0;
      m_writes = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("rst_busy", fsm_busy, 0);
            chk("rst_rd", mem_read_en, 0);
            chk("rst_addr", memory_address, 0);
            chk("rst_wr", write_data_array, 0);
            chk("rst_off", data_word_offset, 0);
            chk("rst_fill", fill_data, 0);
            chk("rst_tag", write_tag_array, 0);
            chk("rst_done", fill_done, 0);
            m_active = 0;
            m_reads  = 0;
            m_writes = 0;
         end else begin
            e_busy = m_active || miss_detected;
            e_rd   = m_active && (m_reads < 8) && mem_grant;
            e_addr = {m_base, 3'((m_start + m_reads) % 8), 1'b0};
            e_wr   = m_active && memory_data_valid && (m_writes < m_reads);
            e_off  = 3'((m_start + m_writes) % 8);
            e_done = e_wr && (m_writes == 7);
            chk("busy", fsm_busy, e_busy);
            chk("rd_en", mem_read_en, e_rd);
            if (e_rd) chk("rd_addr", memory_address, e_addr);
            chk("wr_data", write_data_array, e_wr);
            if (e_wr) begin
               chk("wr_off", data_word_offset, e_off);
               chk("wr_fill", fill_data, memory_data);
            end
            chk("wr_tag", write_tag_array, e_done);
            chk("fill_done", fill_done, e_done);
            if (!m_active && miss_detected) begin
               m_active = 1;
               m_base   = miss_address[15:4];
`ifdef CACHE_FILL_CRIT_WORD_EN
               m_start  = miss_address[3:1];
`else
               m_start  = '0;
`endif
               m_reads  = 0;
               m_writes = 0;
            end else begin
               if (e_rd) m_reads++;
               if (e_wr) m_writes++;
               if (e_done) m_active = 0;
            end
         end
         if (mem_read_en) begin
            mem_q.push_back('{due: cyc + 4, d: memory_address ^ 16'h5A5A});
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(memory_address);
         end
         if (write_data_array) off_q.push_back(data_word_offset);
         if (fill_done) done_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rec();
      rd_cyc_q.delete();
      rd_addr_q.delete();
      off_q.delete();
      done_q.delete();
   endtask

   // Advance until n fill_done pulses are seen; with gap, grant is low in cycles t0+5..7.
   task automatic run_until_done(input int n, input int t0, input bit gap);
      for (int k = 0; k <= 60; k++) begin
         @(negedge clk);
         if (done_q.size() >= n) break;
         if (k == 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pulses expected %0d", done_q.size(), n);
            break;
         end
         tick();
         if (gap) mem_grant = !((cyc - t0) >= 5 && (cyc - t0) <= 7);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish by 100us");
      $fatal(1);
   end

   initial begin
      int t0;
      logic [15:0] a1_first;
      logic [2:0]  o1_first;
      logic [2:0]  o1_last;
      logic [15:0] a2_fifth;
      logic [15:0] b2_first;
      logic [15:0] b2_last;
      logic [2:0]  ob2_first;
`ifdef CACHE_FILL_CRIT_WORD_EN
      a1_first = 16'h1236; o1_first = 3'd3; o1_last = 3'd2; a2_fifth = 16'h123E;
      b2_first = 16'h4A58; b2_last = 16'h4A56; ob2_first = 3'd4;
`else
      a1_first = 16'h1230; o1_first = 3'd0; o1_last = 3'd7; a2_fifth = 16'h1238;
      b2_first = 16'h4A50; b2_last = 16'h4A5E; ob2_first = 3'd0;
`endif
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      miss_detected = 1'b0;
      miss_address = '0;
      mem_grant = 1'b0;
      inj_v = 1'b0;
      inj_d = '0;

      repeat (2) tick();
      @(negedge clk);
      chk("reset_busy", fsm_busy, 0);
      chk("reset_addr", memory_address, 0);
      tick();
      rst = 1'b1;
      repeat (2) tick();

      // Plain fill, grant already high.
      clear_rec();
      mem_grant = 1'b1;
      miss_detected = 1'b1;
      miss_address = 16'h1236;
      t0 = cyc;
      run_until_done(1, t0, 0);
      tick();
      miss_detected = 1'b0;
      repeat (2) tick();
      chk("t1_first_rd_cyc", rd_cyc_q[0] - t0, 1);
      chk("t1_first_addr", rd_addr_q[0], a1_first);
      chk("t1_last_rd_cyc", rd_cyc_q[7] - t0, 8);
      chk("t1_reads", rd_cyc_q.size(), 8);
      chk("t1_writes", off_q.size(), 8);
      chk("t1_first_off", off_q[0], o1_first);
      chk("t1_last_off", off_q[7], o1_last);
      chk("t1_done_cyc", done_q[0] - t0, 12);

      // Three-cycle grant gap after the fourth issue.
      clear_rec();
      miss_detected = 1'b1;
      miss_address = 16'h1236;
      t0 = cyc;
      run_until_done(1, t0, 1);
      tick();
      miss_detected = 1'b0;
      mem_grant = 1'b1;
      repeat (2) tick();
      chk("t2_fifth_rd_cyc", rd_cyc_q[4] - t0, 8);
      chk("t2_fifth_addr", rd_addr_q[4], a2_fifth);
      chk("t2_done_cyc", done_q[0] - t0, 15);

      // Reset for one cycle in the drain phase.
      clear_rec();
      miss_detected = 1'b1;
      miss_address = 16'h1236;
      t0 = cyc;
      repeat (10) tick();
      rst = 1'b0;
      miss_detected = 1'b0;
      @(negedge clk);
      chk("t3_rst_busy", fsm_busy, 0);
      chk("t3_rst_wr", write_data_array, 0);
      tick();
      rst = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      chk("t3_writes", off_q.size(), 5);
      chk("t3_no_done", done_q.size(), 0);
      chk("t3_idle_busy", fsm_busy, 0);
      tick();

      // Stray return while idle.
      inj_v = 1'b1;
      inj_d = 16'hBEEF;
      @(negedge clk);
      chk("t4_idle_wr", write_data_array, 0);
      chk("t4_idle_busy", fsm_busy, 0);
      tick();
      inj_v = 1'b0;
      tick();

      // Back-to-back misses, miss held across fill_done.
      clear_rec();
      miss_detected = 1'b1;
      miss_address = 16'h1236;
      t0 = cyc;
      run_until_done(1, t0, 0);
      tick();
      miss_address = 16'h4A58;
      run_until_done(2, t0, 0);
      tick();
      miss_detected = 1'b0;
      repeat (3) tick();
      chk("t5_done1_cyc", done_q[0] - t0, 12);
      chk("t5_second_rd_cyc", rd_cyc_q[8] - t0, 14);
      chk("t5_second_addr", rd_addr_q[8], b2_first);
      chk("t5_second_last_addr", rd_addr_q[15], b2_last);
      chk("t5_second_off", off_q[8], ob2_first);
      chk("t5_done2_cyc", done_q[1] - t0, 25);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
